// File: rtl/svnet_free_space_fifo.sv
//==============================================================================
// svnet_free_space_fifo
// Credit-target FIFO: publishes free_space and presents buffered words show-ahead.
// Optional high-water mark: define SVNET_FREE_SPACE_FIFO_WATERMARK_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module svnet_free_space_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [$clog2(DEPTH):0]   free_space,
  input  logic                     write,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     read_valid,
  input  logic                     read,
  output logic [WIDTH-1:0]         read_data
`ifdef SVNET_FREE_SPACE_FIFO_WATERMARK_EN
  ,output logic [$clog2(DEPTH):0]  max_used
  ,input  logic                    watermark_clear
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [CW-1:0]    count_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_nxt;
  logic [AW-1:0]    rd_ptr_nxt;

  // Explicit wrap compare so non-power-of-two depths wrap at DEPTH-1.
  assign wr_ptr_nxt = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + AW'(1);
  assign rd_ptr_nxt = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_q + CW'(write) - CW'(read);
      if (write) wr_ptr_q <= wr_ptr_nxt;
      if (read)  rd_ptr_q <= rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr_q] <= write_data;
  end

  assign free_space = DEPTH_C - count_q;
  assign read_valid = (count_q != '0);
  assign read_data  = mem[rd_ptr_q];

`ifdef SVNET_FREE_SPACE_FIFO_WATERMARK_EN
  logic [CW-1:0] max_used_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_used_q <= '0;
    end else if (watermark_clear) begin
      max_used_q <= count_q;
    end else if (count_q > max_used_q) begin
      max_used_q <= count_q;
    end
  end

  assign max_used = max_used_q;
`endif

`ifndef SYNTHESIS
  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    write |-> free_space != '0);
  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    read |-> read_valid);
  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);

  final begin
    if (rst_n && count_q != '0)
      $error("svnet_free_space_fifo: %0d words stranded at end of simulation", count_q);
  end
`endif

endmodule

`default_nettype wire
